// File: rtl/tim_cfg_pkg.sv
// +--------------------------------------------------------------------------+
// | tim_cfg_pkg : register offsets, FSM states and op decoding for tim_cfg_seq |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package tim_cfg_pkg;

  localparam logic [7:0] T1_LOAD = 8'h00;
  localparam logic [7:0] T1_CTRL = 8'h08;
  localparam logic [7:0] T2_LOAD = 8'h14;
  localparam logic [7:0] T2_CTRL = 8'h1C;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ACCESS    = 3'd2,
    GAP       = 3'd3,
    RB_SETUP  = 3'd4,
    RB_ACCESS = 3'd5,
    FIN       = 3'd6
  } state_e;

  typedef enum logic {
    REG_LOAD = 1'b0,
    REG_CTRL = 1'b1
  } reg_e;

  typedef enum logic [1:0] {
    DSEL_ZERO = 2'd0,
    DSEL_LOAD = 2'd1,
    DSEL_CTRL = 2'd2
  } dsel_e;

  typedef struct packed {
    logic  timer;   // 0 = timer 1, 1 = timer 2
    reg_e  regsel;
    dsel_e dsel;
  } op_t;

  // Ops 0..2 program timer 1, ops 3..5 timer 2: disable, load, control.
  function automatic op_t decode_op(input logic [2:0] idx);
    op_t op;
    op.timer = (idx > 3'd2);
    case (idx)
      3'd1, 3'd4: begin op.regsel = REG_LOAD; op.dsel = DSEL_LOAD; end
      3'd2, 3'd5: begin op.regsel = REG_CTRL; op.dsel = DSEL_CTRL; end
      default:    begin op.regsel = REG_CTRL; op.dsel = DSEL_ZERO; end
    endcase
    return op;
  endfunction

  function automatic logic [7:0] op_offset(input op_t op);
    case ({op.timer, op.regsel})
      {1'b0, REG_LOAD}: return T1_LOAD;
      {1'b0, REG_CTRL}: return T1_CTRL;
      {1'b1, REG_LOAD}: return T2_LOAD;
      default:          return T2_CTRL;
    endcase
  endfunction

  function automatic logic [31:0] op_data(input op_t op, input logic [31:0] l1,
                                          input logic [31:0] l2, input logic [2:0] c1,
                                          input logic [2:0] c2);
    case (op.dsel)
      DSEL_LOAD: return op.timer ? l2 : l1;
      DSEL_CTRL: return {29'd0, (op.timer ? c2 : c1)};
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] first_op(input logic [1:0] sel);
    return sel[0] ? 3'd0 : 3'd3;
  endfunction

  function automatic logic op_is_last(input logic [2:0] idx, input logic [1:0] sel);
    return (idx == 3'd5) || (idx == 3'd2 && !sel[1]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tim_cfg_seq_if.sv
// +--------------------------------------------------------------------------+
// | tim_cfg_seq_if : APB bus between the sequencer and the timer slave        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface tim_cfg_seq_if #(
  parameter int ADDR_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

`default_nettype wire

// File: rtl/tim_cfg_apb_if.sv
// +--------------------------------------------------------------------------+
// | tim_cfg_apb_if : single-transfer APB master, req/ack, no wait states      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tim_cfg_apb_if #(
  parameter int ADDR_W = 8
) (
  input  wire logic              pclk,
  input  wire logic              presetn,
  input  wire logic              req,
  input  wire logic              write,
  input  wire logic [ADDR_W-1:0] addr,
  input  wire logic [31:0]       wdata,
  output logic                   ack,
  output logic [31:0]            rdata,
  tim_cfg_seq_if.master          apb
);

  // A new request is taken while idle or in the ACCESS cycle, so transfers can abut.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
    end else if (req && (!apb.psel || apb.penable)) begin
      apb.psel    <= 1'b1;
      apb.penable <= 1'b0;
      apb.pwrite  <= write;
      apb.paddr   <= addr;
      apb.pwdata  <= wdata;
    end else if (apb.psel && !apb.penable) begin
      apb.penable <= 1'b1;
    end else begin
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
    end
  end

  assign ack   = apb.penable;
  assign rdata = apb.prdata;

endmodule

`default_nettype wire

// File: rtl/tim_cfg_seq.sv
// +--------------------------------------------------------------------------+
// | tim_cfg_seq : APB write sequencer programming the dual-timer peripheral   |
// | Optional readback check: TIM_CFG_SEQ_READBACK_EN.   Rev 1.0               |
// +--------------------------------------------------------------------------+
`default_nettype none

module tim_cfg_seq
  import tim_cfg_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int GAP_CYC = 0
) (
  input  wire logic        pclk,
  input  wire logic        presetn,
  input  wire logic        start,
  input  wire logic [1:0]  tim_sel,
  input  wire logic [31:0] load1,
  input  wire logic [31:0] load2,
  input  wire logic [2:0]  ctrl1,
  input  wire logic [2:0]  ctrl2,
  output logic             busy,
  output logic             done,
  output logic             err,
  tim_cfg_seq_if.master    apb
);

`ifdef TIM_CFG_SEQ_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  state_e      r_state;
  logic [2:0]  r_op;
  logic        r_rd;
  logic [3:0]  r_gap_cnt;
  logic [1:0]  r_sel;
  logic [31:0] r_load1, r_load2;
  logic [2:0]  r_ctrl1, r_ctrl2;
  logic        r_busy, r_done, r_err;

  logic              w_req, w_req_rd, w_ack;
  logic [2:0]        w_req_op;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata, w_rdata, w_cur_data;
  logic              w_rb_bad, w_cont_last, w_cont_rd;
  logic [2:0]        w_cont_op;
  op_t               w_cur, w_req_dec;

  assign w_cur      = decode_op(r_op);
  assign w_cur_data = op_data(w_cur, r_load1, r_load2, r_ctrl1, r_ctrl2);
  assign w_rb_bad   = (w_cur.regsel == REG_CTRL) ? (w_rdata[2:0] != w_cur_data[2:0])
                                                 : (w_rdata != w_cur_data);

  // What follows the transfer now in ACCESS/RB_ACCESS.
  always_comb begin
    w_cont_rd   = 1'b0;
    w_cont_op   = r_op + 3'd1;
    w_cont_last = op_is_last(r_op, r_sel);
    if (r_state == ACCESS && RB_EN && w_cur.dsel != DSEL_ZERO) begin
      w_cont_rd   = 1'b1;
      w_cont_op   = r_op;
      w_cont_last = 1'b0;
    end else if (r_state == RB_ACCESS && w_rb_bad) begin
      w_cont_last = 1'b1;
    end
  end

  // The request is raised one cycle ahead so SETUP lands in the next state.
  always_comb begin
    w_req    = 1'b0;
    w_req_op = w_cont_op;
    w_req_rd = w_cont_rd;
    case (r_state)
      IDLE: if (start && tim_sel != 2'b00) begin
        w_req    = 1'b1;
        w_req_op = first_op(tim_sel);
        w_req_rd = 1'b0;
      end
      ACCESS, RB_ACCESS: w_req = w_ack && !w_cont_last && (GAP_CYC == 0);
      GAP: if (r_gap_cnt == 4'(GAP_CYC - 1)) begin
        w_req    = 1'b1;
        w_req_op = r_op;
        w_req_rd = r_rd;
      end
      default: ;
    endcase
  end

  assign w_req_dec = decode_op(w_req_op);
  assign w_addr    = ADDR_W'(op_offset(w_req_dec));
  assign w_wdata   = op_data(w_req_dec, r_load1, r_load2, r_ctrl1, r_ctrl2);

  tim_cfg_apb_if #(.ADDR_W(ADDR_W)) u_apb (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (w_req),
    .write   (!w_req_rd),
    .addr    (w_addr),
    .wdata   (w_wdata),
    .ack     (w_ack),
    .rdata   (w_rdata),
    .apb     (apb)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= IDLE;
      r_op      <= 3'd0;
      r_rd      <= 1'b0;
      r_gap_cnt <= 4'd0;
      r_sel     <= 2'b00;
      r_load1   <= 32'd0;
      r_load2   <= 32'd0;
      r_ctrl1   <= 3'd0;
      r_ctrl2   <= 3'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          if (tim_sel != 2'b00) begin
            r_sel   <= tim_sel;
            r_load1 <= load1;
            r_load2 <= load2;
            r_ctrl1 <= ctrl1;
            r_ctrl2 <= ctrl2;
            r_op    <= first_op(tim_sel);
            r_rd    <= 1'b0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= SETUP;
          end else begin
            r_done  <= 1'b1;
            r_state <= FIN;
          end
        end
        SETUP:    r_state <= ACCESS;
        RB_SETUP: r_state <= RB_ACCESS;
        ACCESS, RB_ACCESS: if (w_ack) begin
`ifdef TIM_CFG_SEQ_READBACK_EN
          if (r_state == RB_ACCESS && w_rb_bad) r_err <= 1'b1;
`endif
          if (w_cont_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= FIN;
          end else begin
            r_op <= w_cont_op;
            r_rd <= w_cont_rd;
            if (GAP_CYC == 0) begin
              r_state <= w_cont_rd ? RB_SETUP : SETUP;
            end else begin
              r_gap_cnt <= 4'd0;
              r_state   <= GAP;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == 4'(GAP_CYC - 1)) r_state <= r_rd ? RB_SETUP : SETUP;
          else                              r_gap_cnt <= r_gap_cnt + 4'd1;
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tim_cfg_seq.sv
// +--------------------------------------------------------------------------+
// | tb_tim_cfg_seq : directed self-checking bench for tim_cfg_seq             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_tim_cfg_seq;

`ifdef TIM_CFG_SEQ_READBACK_EN
  localparam int EXP_BOTH = 21;
  localparam int EXP_T2   = 11;
  localparam int EXP_GAP  = 39;
  localparam int EXP_PSEL_GAP = 20;
`else
  localparam int EXP_BOTH = 13;
  localparam int EXP_T2   = 7;
  localparam int EXP_GAP  = 23;
  localparam int EXP_PSEL_GAP = 12;
`endif

  logic        clk = 1'b0;
  logic        presetn = 1'b0;
  logic        start_0 = 1'b0, start_g = 1'b0;
  logic [1:0]  tim_sel = 2'b00;
  logic [31:0] load1 = 32'd0, load2 = 32'd0;
  logic [2:0]  ctrl1 = 3'd0, ctrl2 = 3'd0;
  logic        busy_0, done_0, err_0, busy_g, done_g, err_g;
  logic        bad_rb = 1'b0;
  logic        sel_gap = 1'b0;

  logic [31:0] mem0 [256];
  logic [31:0] memg [256];

  int total = 0;
  int bad   = 0;

  logic [7:0]  log_addr [16];
  logic [31:0] log_data [16];
  int          log_cyc  [16];
  int log_n, done_cyc, done_cnt, busy_first, busy_last, busy_cnt, psel_cnt, stab_err, rd_cnt;

  always #5 clk = ~clk;

  tim_cfg_seq_if #(.ADDR_W(8)) b0 ();
  tim_cfg_seq_if #(.ADDR_W(8)) bg ();

  tim_cfg_seq #(.ADDR_W(8), .GAP_CYC(0)) u_dut (
    .pclk(clk), .presetn(presetn), .start(start_0), .tim_sel(tim_sel),
    .load1(load1), .load2(load2), .ctrl1(ctrl1), .ctrl2(ctrl2),
    .busy(busy_0), .done(done_0), .err(err_0), .apb(b0.master)
  );

  tim_cfg_seq #(.ADDR_W(8), .GAP_CYC(2)) u_gap (
    .pclk(clk), .presetn(presetn), .start(start_g), .tim_sel(tim_sel),
    .load1(load1), .load2(load2), .ctrl1(ctrl1), .ctrl2(ctrl2),
    .busy(busy_g), .done(done_g), .err(err_g), .apb(bg.master)
  );

  // Register-file slave model; bad_rb corrupts the T1_LOAD readback.
  always @(posedge clk) begin
    if (b0.psel && b0.penable && b0.pwrite) mem0[b0.paddr] <= b0.pwdata;
    if (bg.psel && bg.penable && bg.pwrite) memg[bg.paddr] <= bg.pwdata;
  end
  assign b0.prdata = (bad_rb && b0.paddr == 8'h00) ? 32'h0000_0FFF : mem0[b0.paddr];
  assign bg.prdata = (bad_rb && bg.paddr == 8'h00) ? 32'h0000_0FFF : memg[bg.paddr];

  wire        o_psel    = sel_gap ? bg.psel    : b0.psel;
  wire        o_penable = sel_gap ? bg.penable : b0.penable;
  wire        o_pwrite  = sel_gap ? bg.pwrite  : b0.pwrite;
  wire [7:0]  o_paddr   = sel_gap ? bg.paddr   : b0.paddr;
  wire [31:0] o_pwdata  = sel_gap ? bg.pwdata  : b0.pwdata;
  wire        o_busy    = sel_gap ? busy_g     : busy_0;
  wire        o_done    = sel_gap ? done_g     : done_0;
  wire        o_err     = sel_gap ? err_g      : err_0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulse start in cycle 0 and record bus/status activity for cycles 1..ncyc.
  task automatic run(input bit use_gap, input int ncyc, input int restart_at, input int chg_at);
    logic p_psel, p_pen, p_wr;
    logic [7:0] p_addr;
    logic [31:0] p_data;
    sel_gap = use_gap;
    log_n = 0; done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1;
    busy_cnt = 0; psel_cnt = 0; stab_err = 0; rd_cnt = 0;
    p_psel = 1'b0; p_pen = 1'b0; p_wr = 1'b0; p_addr = 8'd0; p_data = 32'd0;
    if (use_gap) start_g = 1'b1; else start_0 = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      start_0 = !use_gap && (k == restart_at);
      start_g = use_gap && (k == restart_at);
      if (k == chg_at) load1 = 32'hDEAD_BEEF;
      if (o_done) begin done_cnt++; if (done_cyc < 0) done_cyc = k; end
      if (o_busy) begin busy_cnt++; if (busy_first < 0) busy_first = k; busy_last = k; end
      if (o_psel) psel_cnt++;
      if (o_psel && o_penable) begin
        if (!(p_psel && !p_pen) || o_paddr !== p_addr || o_pwdata !== p_data || o_pwrite !== p_wr)
          stab_err++;
        if (o_pwrite) begin
          if (log_n < 16) begin
            log_addr[log_n] = o_paddr; log_data[log_n] = o_pwdata; log_cyc[log_n] = k;
          end
          log_n++;
        end else rd_cnt++;
      end
      p_psel = o_psel; p_pen = o_penable; p_wr = o_pwrite; p_addr = o_paddr; p_data = o_pwdata;
    end
    start_0 = 1'b0; start_g = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({b0.psel, b0.penable, b0.pwrite, busy_0, done_0, err_0} !== 6'b0)
      begin bad++; $display("FAIL reset_ctl got=%b want=000000", {b0.psel, b0.penable, b0.pwrite, busy_0, done_0, err_0}); end
    total++;
    if (b0.paddr !== 8'd0 || b0.pwdata !== 32'd0)
      begin bad++; $display("FAIL reset_bus got=%h/%h want=00/00000000", b0.paddr, b0.pwdata); end
    total++;
    if ({bg.psel, bg.penable, busy_g, done_g, err_g} !== 5'b0)
      begin bad++; $display("FAIL reset_gap got=%b want=00000", {bg.psel, bg.penable, busy_g, done_g, err_g}); end
  endtask

  task automatic test_both();
    logic [7:0]  ea [6] = '{8'h08, 8'h00, 8'h08, 8'h1C, 8'h14, 8'h1C};
    logic [31:0] ed [6] = '{32'h0, 32'h0000_1000, 32'h3, 32'h0, 32'hFFFF_FFFF, 32'h1};
    tim_sel = 2'b11; load1 = 32'h0000_1000; ctrl1 = 3'b011; load2 = 32'hFFFF_FFFF; ctrl2 = 3'b001;
    run(1'b0, 30, -1, -1);
    total++;
    if (log_n != 6) begin bad++; $display("FAIL both_nwr got=%0d want=6", log_n); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i < log_n && (log_addr[i] !== ea[i] || log_data[i] !== ed[i])) begin
        bad++; $display("FAIL both_wr%0d got=%h/%h want=%h/%h", i, log_addr[i], log_data[i], ea[i], ed[i]);
      end else if (i >= log_n) begin
        bad++; $display("FAIL both_wr%0d got=missing want=%h/%h", i, ea[i], ed[i]);
      end
    end
    total++;
    if (done_cyc != EXP_BOTH || done_cnt != 1)
      begin bad++; $display("FAIL both_done got=cyc%0d x%0d want=cyc%0d x1", done_cyc, done_cnt, EXP_BOTH); end
    total++;
    if (busy_first != 1 || busy_last != EXP_BOTH - 1 || busy_cnt != EXP_BOTH - 1)
      begin bad++; $display("FAIL both_busy got=%0d..%0d n%0d want=1..%0d", busy_first, busy_last, busy_cnt, EXP_BOTH - 1); end
    total++;
    if (stab_err != 0 || o_err !== 1'b0)
      begin bad++; $display("FAIL both_apb got=stab%0d err%b want=stab0 err0", stab_err, o_err); end
  endtask

  task automatic test_timer2();
    tim_sel = 2'b10; load2 = 32'h1234_5678; ctrl2 = 3'b110;
    run(1'b0, 20, -1, -1);
    total++;
    if (log_n != 3 || log_addr[0] !== 8'h1C || log_addr[1] !== 8'h14 || log_addr[2] !== 8'h1C)
      begin bad++; $display("FAIL t2_addr got=n%0d %h %h %h want=n3 1c 14 1c", log_n, log_addr[0], log_addr[1], log_addr[2]); end
    total++;
    if (log_data[0] !== 32'h0 || log_data[1] !== 32'h1234_5678 || log_data[2] !== 32'h6)
      begin bad++; $display("FAIL t2_data got=%h %h %h want=0 12345678 6", log_data[0], log_data[1], log_data[2]); end
    total++;
    if (done_cyc != EXP_T2) begin bad++; $display("FAIL t2_done got=%0d want=%0d", done_cyc, EXP_T2); end
  endtask

  task automatic test_none();
    tim_sel = 2'b00;
    run(1'b0, 6, -1, -1);
    total++;
    if (done_cyc != 1 || done_cnt != 1)
      begin bad++; $display("FAIL none_done got=cyc%0d x%0d want=cyc1 x1", done_cyc, done_cnt); end
    total++;
    if (busy_cnt != 0 || psel_cnt != 0)
      begin bad++; $display("FAIL none_idle got=busy%0d psel%0d want=0 0", busy_cnt, psel_cnt); end
  endtask

  task automatic test_back_to_back();
    tim_sel = 2'b11; load1 = 32'h0000_1000; ctrl1 = 3'b011; load2 = 32'hFFFF_FFFF; ctrl2 = 3'b001;
    run(1'b0, 30, 5, 3);
    total++;
    if (log_n != 6 || log_data[1] !== 32'h0000_1000)
      begin bad++; $display("FAIL b2b_capture got=n%0d load%h want=n6 load00001000", log_n, log_data[1]); end
    total++;
    if (done_cyc != EXP_BOTH || done_cnt != 1)
      begin bad++; $display("FAIL b2b_done got=cyc%0d x%0d want=cyc%0d x1", done_cyc, done_cnt, EXP_BOTH); end
    load1 = 32'h0000_1000;
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    sel_gap = 1'b0; tim_sel = 2'b11;
    start_0 = 1'b1; tick(); start_0 = 1'b0; tick();
    total++;
    if (!(b0.psel && b0.penable)) begin bad++; $display("FAIL rst_pre got=%b%b want=11", b0.psel, b0.penable); end
    presetn = 1'b0; #1;
    total++;
    if ({b0.psel, b0.penable, busy_0} !== 3'b000)
      begin bad++; $display("FAIL rst_async got=%b want=000", {b0.psel, b0.penable, busy_0}); end
    #2; presetn = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); if (b0.psel || busy_0 || done_0) stray++; end
    total++;
    if (stray != 0) begin bad++; $display("FAIL rst_resume got=%0d want=0", stray); end
    run(1'b0, 30, -1, -1);
    total++;
    if (log_n != 6 || done_cyc != EXP_BOTH)
      begin bad++; $display("FAIL rst_rerun got=n%0d cyc%0d want=n6 cyc%0d", log_n, done_cyc, EXP_BOTH); end
  endtask

  task automatic test_gap();
    tim_sel = 2'b11; load1 = 32'h0000_1000; ctrl1 = 3'b011; load2 = 32'hFFFF_FFFF; ctrl2 = 3'b001;
    run(1'b1, 50, -1, -1);
    total++;
    if (log_n != 6 || log_addr[5] !== 8'h1C || log_data[4] !== 32'hFFFF_FFFF)
      begin bad++; $display("FAIL gap_wr got=n%0d %h %h want=n6 1c ffffffff", log_n, log_addr[5], log_data[4]); end
    total++;
    if (done_cyc != EXP_GAP) begin bad++; $display("FAIL gap_done got=%0d want=%0d", done_cyc, EXP_GAP); end
    total++;
    if (psel_cnt != EXP_PSEL_GAP || stab_err != 0)
      begin bad++; $display("FAIL gap_psel got=%0d stab%0d want=%0d stab0", psel_cnt, stab_err, EXP_PSEL_GAP); end
`ifndef TIM_CFG_SEQ_READBACK_EN
    total++;
    if (log_cyc[0] != 2 || log_cyc[1] != 6 || log_cyc[5] != 22)
      begin bad++; $display("FAIL gap_spacing got=%0d %0d %0d want=2 6 22", log_cyc[0], log_cyc[1], log_cyc[5]); end
`endif
    sel_gap = 1'b0;
  endtask

  task automatic test_readback();
    tim_sel = 2'b11; load1 = 32'h0000_1000; ctrl1 = 3'b011; load2 = 32'hFFFF_FFFF; ctrl2 = 3'b001;
    bad_rb = 1'b1;
    run(1'b0, 30, -1, -1);
    bad_rb = 1'b0;
`ifdef TIM_CFG_SEQ_READBACK_EN
    total++;
    if (o_err !== 1'b1) begin bad++; $display("FAIL rb_err got=%b want=1", o_err); end
    total++;
    if (log_n != 2 || rd_cnt != 1)
      begin bad++; $display("FAIL rb_abort got=wr%0d rd%0d want=wr2 rd1", log_n, rd_cnt); end
    total++;
    if (done_cyc != 7 || done_cnt != 1)
      begin bad++; $display("FAIL rb_done got=cyc%0d x%0d want=cyc7 x1", done_cyc, done_cnt); end
    run(1'b0, 30, -1, -1);
    total++;
    if (o_err !== 1'b0 || rd_cnt != 4 || log_n != 6)
      begin bad++; $display("FAIL rb_good got=err%b rd%0d wr%0d want=err0 rd4 wr6", o_err, rd_cnt, log_n); end
`else
    total++;
    if (o_err !== 1'b0 || rd_cnt != 0 || log_n != 6)
      begin bad++; $display("FAIL rb_off got=err%b rd%0d wr%0d want=err0 rd0 wr6", o_err, rd_cnt, log_n); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem0[i] = 32'd0; memg[i] = 32'd0; end
    repeat (3) tick();
    test_reset();
    presetn = 1'b1;
    tick(); tick();
    test_both();
    test_timer2();
    test_none();
    test_back_to_back();
    test_reset_mid();
    test_gap();
    test_readback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
